// File: rtl/alu_pkg.sv
// ALU op codes and widths shared by the ALU, the main decoder and the ALU share arbiter.
package alu_pkg;

  localparam int ALU_W      = 32;
  localparam int ALU_CTRL_W = 3;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  // Width of an index into n requesters, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps, first requester found wins.
module rr_arbiter
  import alu_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  // Scan requesters starting from ptr and grant the first valid one when enabled.
  always_comb begin : search
    logic found;
    int   cand;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(ptr) + i) % N;
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one registered ALU between N_REQ requesters with round-robin issue and tagged responses.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int ALU_LAT = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic                           flush,
  input  logic [N_REQ-1:0]               req_valid,
  output logic [N_REQ-1:0]               req_ready,
  input  logic [N_REQ*ALU_W-1:0]         req_a,
  input  logic [N_REQ*ALU_W-1:0]         req_b,
  input  logic [N_REQ*ALU_CTRL_W-1:0]    req_ctrl,
  output logic [ALU_W-1:0]               alu_a,
  output logic [ALU_W-1:0]               alu_b,
  output logic [ALU_CTRL_W-1:0]          alu_ctrl,
  input  logic [ALU_W-1:0]               alu_res,
  input  logic                           alu_zero,
  output logic [N_REQ-1:0]               rsp_valid,
  output logic [ALU_W-1:0]               rsp_res,
  output logic                           rsp_zero,
  output logic [$clog2(ALU_LAT+2)-1:0]   inflight
);

  localparam int IW    = idx_width(N_REQ);
  localparam int INF_W = $clog2(ALU_LAT+2);

  logic [IW-1:0]            ptr;
  logic [IW-1:0]            gnt_idx;
  logic                     grant_en;
  logic                     accept;
  logic [ALU_LAT:0]         pipe_valid;
  logic [ALU_LAT:0][IW-1:0] pipe_tag;

  assign grant_en = !(stall || flush || rst);
  assign accept   = |(req_valid & req_ready);

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (ptr),
    .en      (grant_en),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx)
  );

  // Issue register: latch the winner's operands and move priority just past the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= '0;
    end else if (accept) begin
      ptr      <= (int'(gnt_idx) == N_REQ-1) ? '0 : gnt_idx + 1'b1;
      alu_a    <= req_a[int'(gnt_idx)*ALU_W +: ALU_W];
      alu_b    <= req_b[int'(gnt_idx)*ALU_W +: ALU_W];
      alu_ctrl <= req_ctrl[int'(gnt_idx)*ALU_CTRL_W +: ALU_CTRL_W];
    end
  end

  // Tag pipe tracks which requester owns each op in flight; a flush kills every stage at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
      pipe_tag   <= '0;
    end else begin
      pipe_valid[0] <= accept;
      pipe_tag[0]   <= gnt_idx;
      for (int i = 1; i <= ALU_LAT; i++) begin
        pipe_valid[i] <= flush ? 1'b0 : pipe_valid[i-1];
        pipe_tag[i]   <= pipe_tag[i-1];
      end
      if (flush) pipe_valid[0] <= 1'b0;
    end
  end

  // Route the ALU result to its owner using the tag at the end of the pipe.
  always_comb begin
    rsp_valid = '0;
    if (pipe_valid[ALU_LAT]) rsp_valid[pipe_tag[ALU_LAT]] = 1'b1;
  end

  assign rsp_res  = alu_res;
  assign rsp_zero = alu_zero;

  // Count live ops in the pipe.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= ALU_LAT; i++) inflight = inflight + INF_W'(pipe_valid[i]);
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Table-driven bench with a response scoreboard for alu_share_arbiter (N_REQ=2, ALU_LAT=1).
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int N_REQ   = 2;
  localparam int ALU_LAT = 1;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [5:0]  req_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_res;
  logic        rsp_zero;
  logic [1:0]  inflight;

  alu_share_arbiter #(.N_REQ(N_REQ), .ALU_LAT(ALU_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ctrl  (req_ctrl),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctrl  (alu_ctrl),
    .alu_res   (alu_res),
    .alu_zero  (alu_zero),
    .rsp_valid (rsp_valid),
    .rsp_res   (rsp_res),
    .rsp_zero  (rsp_zero),
    .inflight  (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ALU attached to the arbiter, one edge from operands to result.
  always_ff @(posedge clk) begin
    case (alu_ctrl)
      ALU_AND: alu_res <= alu_a & alu_b;
      ALU_OR:  alu_res <= alu_a | alu_b;
      ALU_ADD: alu_res <= alu_a + alu_b;
      ALU_SUB: alu_res <= alu_a - alu_b;
      ALU_SLT: alu_res <= {31'b0, ($signed(alu_a) < $signed(alu_b))};
      default: alu_res <= 32'h0;
    endcase
    alu_zero <= (alu_a == alu_b);
  end

  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic [1:0]  valid;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [2:0]  c0;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [2:0]  c1;
    logic [1:0]  exp_ready;
    logic [31:0] exp_res;
    logic        exp_zero;
    logic        chk_clr;
  } vec_t;

  typedef struct {
    int          due;
    logic [1:0]  onehot;
    logic [31:0] res;
    logic        zero;
  } rsp_t;

  vec_t vecs[$];
  rsp_t sb[$];
  int   tests;
  int   fails;

  task automatic addRow(input logic r, input logic s, input logic f, input logic [1:0] v,
                        input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] c0,
                        input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] c1,
                        input logic [1:0] er, input logic [31:0] eres, input logic ez,
                        input logic clr);
    vec_t t;
    t.rst = r; t.stall = s; t.flush = f; t.valid = v;
    t.a0 = a0; t.b0 = b0; t.c0 = c0; t.a1 = a1; t.b1 = b1; t.c1 = c1;
    t.exp_ready = er; t.exp_res = eres; t.exp_zero = ez; t.chk_clr = clr;
    vecs.push_back(t);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      addRow(0, 0, 0, 2'b00, 0, 0, ALU_AND, 0, 0, ALU_AND, 2'b00, 0, 0, 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst       = v.rst;
    stall     = v.stall;
    flush     = v.flush;
    req_valid = v.valid;
    req_a     = {v.a1, v.a0};
    req_b     = {v.b1, v.b0};
    req_ctrl  = {v.c1, v.c0};
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    rsp_t e;
    tests = 0;
    fails = 0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; req_valid = 2'b00;
    req_a = '0; req_b = '0; req_ctrl = '0;
    repeat (2) @(posedge clk);
    #1;

    // reset state, requests ignored under reset
    addRow(1, 0, 0, 2'b11, 1, 2, ALU_ADD, 3, 4, ALU_ADD, 2'b00, 0, 0, 1);
    // single ADD from requester 0
    addRow(0, 0, 0, 2'b01, 5, 3, ALU_ADD, 0, 0, ALU_AND, 2'b01, 32'd8, 0, 0);
    idle(3);
    // contention, pointer starts at requester 1
    for (int i = 0; i < 2; i++) begin
      addRow(0, 0, 0, 2'b11, 10, 4, ALU_SUB, 32'hF0, 32'h3C, ALU_AND, 2'b10, 32'h30, 0, 0);
      addRow(0, 0, 0, 2'b11, 10, 4, ALU_SUB, 32'hF0, 32'h3C, ALU_AND, 2'b01, 32'd6, 0, 0);
    end
    // stall for three cycles, last accepted op still responds
    for (int i = 0; i < 3; i++)
      addRow(0, 1, 0, 2'b11, 10, 4, ALU_SUB, 32'hF0, 32'h3C, ALU_AND, 2'b00, 0, 0, 0);
    addRow(0, 0, 0, 2'b11, 10, 4, ALU_SUB, 32'hF0, 32'h3C, ALU_AND, 2'b10, 32'h30, 0, 0);
    idle(3);
    // flush kills an op still in stage 0
    addRow(0, 0, 0, 2'b01, 100, 23, ALU_ADD, 0, 0, ALU_AND, 2'b01, 32'd123, 0, 0);
    addRow(0, 0, 1, 2'b01, 100, 23, ALU_ADD, 0, 0, ALU_AND, 2'b00, 0, 0, 0);
    idle(1);
    // flush in the cycle a response is visible still delivers it
    addRow(0, 0, 0, 2'b01, 1, 1, ALU_ADD, 0, 0, ALU_AND, 2'b01, 32'd2, 1, 0);
    idle(1);
    addRow(0, 0, 1, 2'b10, 0, 0, ALU_AND, 9, 9, ALU_ADD, 2'b00, 0, 0, 0);
    // SLT with equal operands on requester 1
    addRow(0, 0, 0, 2'b10, 0, 0, ALU_AND, 7, 7, ALU_SLT, 2'b10, 32'd0, 1, 0);
    idle(3);
    // reset mid-operation drops the op and returns priority to requester 0
    addRow(0, 0, 0, 2'b01, 32'h0F, 32'hF0, ALU_OR, 0, 0, ALU_AND, 2'b01, 32'hFF, 0, 0);
    addRow(1, 0, 0, 2'b11, 32'h0F, 32'hF0, ALU_OR, 3, 5, ALU_SLT, 2'b00, 0, 0, 0);
    addRow(0, 0, 0, 2'b11, 3, 5, ALU_SUB, 3, 5, ALU_SLT, 2'b01, 32'hFFFF_FFFE, 0, 1);
    addRow(0, 0, 0, 2'b11, 3, 5, ALU_SUB, 3, 5, ALU_SLT, 2'b10, 32'd1, 0, 0);
    // lone requester granted every cycle
    addRow(0, 0, 0, 2'b10, 0, 0, ALU_AND, 32'hFFFF_FFFF, 1, ALU_ADD, 2'b10, 32'd0, 0, 0);
    addRow(0, 0, 0, 2'b10, 0, 0, ALU_AND, 32'hFFFF_FFFF, 1, ALU_ADD, 2'b10, 32'd0, 0, 0);
    idle(3);
    // unused op code forwarded as is
    addRow(0, 0, 0, 2'b01, 9, 9, 3'b011, 0, 0, ALU_AND, 2'b01, 32'd0, 1, 0);
    idle(3);

    for (int c = 0; c < vecs.size(); c++) begin
      applyStimulus(vecs[c]);
      @(negedge clk);
      checkOutput($sformatf("req_ready row %0d", c), 32'(req_ready), 32'(vecs[c].exp_ready));
      checkOutput($sformatf("inflight row %0d", c), 32'(inflight), 32'(sb.size()));
      if (sb.size() > 0 && sb[0].due == c) begin
        e = sb.pop_front();
        checkOutput($sformatf("rsp_valid row %0d", c), 32'(rsp_valid), 32'(e.onehot));
        checkOutput($sformatf("rsp_res row %0d", c), rsp_res, e.res);
        checkOutput($sformatf("rsp_zero row %0d", c), 32'(rsp_zero), 32'(e.zero));
      end else begin
        checkOutput($sformatf("rsp_valid idle row %0d", c), 32'(rsp_valid), 32'h0);
      end
      if (vecs[c].chk_clr) begin
        checkOutput($sformatf("alu_a clear row %0d", c), alu_a, 32'h0);
        checkOutput($sformatf("alu_b clear row %0d", c), alu_b, 32'h0);
        checkOutput($sformatf("alu_ctrl clear row %0d", c), 32'(alu_ctrl), 32'h0);
      end
      @(posedge clk);
      if (vecs[c].rst || vecs[c].flush) begin
        sb.delete();
      end else if (vecs[c].exp_ready != 2'b00) begin
        e.due    = c + 1 + ALU_LAT;
        e.onehot = vecs[c].exp_ready;
        e.res    = vecs[c].exp_res;
        e.zero   = vecs[c].exp_zero;
        sb.push_back(e);
      end
      #1;
    end

    checkOutput("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
